mano_out_tx: RTL

Output-side device port for the Mano computer. Holds the OUTR register and FGO flag the CPU writes through the OUT instruction, and serialises each accepted byte onto an 8-N-1 asynchronous serial line. FGO returns to 1 when the frame finishes, so SKO/interrupt logic sees the device as ready. It sits between the control unit's I/O decode (OUT = p·B10) and the board's serial TX pin.

---
 rtl/mano_out_tx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mano_out_tx.sv
// Mano computer output port: OUTR/FGO register pair plus an 8-N-1 serial
// transmitter. An accepted byte is shifted out LSB first, and FGO returns to 1 when the frame ends.
module mano_out_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] D,
  input  logic       LD,
  output logic [7:0] OUTR,
  output logic       FGO,
  output logic       BUSY,
  output logic       TXD
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      outr_q,  outr_d;
  logic [7:0]      shift_q, shift_d;
  logic            fgo_q,   fgo_d;
  logic            txd_q,   txd_d;
  logic [2:0]      bit_q,   bit_d;
  logic [BW-1:0]   baud_q,  baud_d;
  logic            baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // NOTE: every always_comb output takes a hold-value default first, so no
  // branch can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    outr_d  = outr_q;
    shift_d = shift_q;
    fgo_d   = fgo_q;
    txd_d   = txd_q;
    bit_d   = bit_q;
    baud_d  = baud_q;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
    end

    unique case (state_q)
      IDLE: begin
        // A load while a frame is in flight (FGO=0) is dropped; the CPU polls SKO.
        if (LD && fgo_q) begin
          outr_d  = D;
          shift_d = D;
          fgo_d   = 1'b0;
          txd_d   = 1'b0;
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q != 3'd7) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end else begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          state_d = IDLE;
          fgo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values computed before the edge.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      outr_q  <= 8'h00;
      shift_q <= 8'h00;
      fgo_q   <= 1'b1;
      txd_q   <= 1'b1;
      bit_q   <= 3'd0;
      baud_q  <= '0;
    end else begin
      state_q <= state_d;
      outr_q  <= outr_d;
      shift_q <= shift_d;
      fgo_q   <= fgo_d;
      txd_q   <= txd_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
    end
  end

  assign OUTR = outr_q;
  assign FGO  = fgo_q;
  assign TXD  = txd_q;
  assign BUSY = (state_q != IDLE);

endmodule
